riscv_imem_loader: RTL and testbench
====================================

// Module: riscv_imem_loader
// PURPOSE
//  Upstream boot stage for riscv_top: receives a program as a little-endian byte stream,
//  packs bytes into 32-bit words and writes them through the instruction-memory write port.
//  Holds the CPU in reset while loading, then releases it to run from PC 0.
//  Sits between the host byte link and riscv_imem; the CPU core is untouched.
// PARAMETERS
//  WORD_ADDR_W  `IMEM_ADDR_BIT-2  imem word-address width; capacity = 2**WORD_ADDR_W words
//  AUTO_START   1                 1: enter HDR right after reset; 0: wait in IDLE for i_ldr_start
// PORTS
//  i_clk               in   1               clock
//  i_rst               in   1               synchronous reset, active-high
//  i_ldr_start         in   1               start/restart pulse (IDLE, RUN, ERR only)
//  i_ldr_valid         in   1               byte valid
//  i_ldr_data          in   8               byte payload
//  o_ldr_ready         out  1               byte accepted when valid&ready
//  o_ldr_imem_wr_en    out  1               imem write strobe, 1 cycle per word
//  o_ldr_imem_addr     out  WORD_ADDR_W     imem word address
//  o_ldr_imem_wr_data  out  `XLEN           packed word
//  o_ldr_cpu_rstn      out  1               CPU reset (active-low, drives riscv_top i_rstn)
//  o_ldr_done          out  1               load complete, CPU running
//  o_ldr_err           out  1               load aborted
// BEHAVIOUR
//  - Reset: state=IDLE (AUTO_START=0) or HDR (AUTO_START=1); all outputs 0 (cpu_rstn=0).
//  - Stream: 4-byte word count N (LSB first), then N words, each LSB first.
//  - IDLE: ready=0; i_ldr_start -> HDR.
//  - HDR: ready=1; 2-bit byte counter; on 4th byte: N=0 -> RUN; N>2**WORD_ADDR_W -> ERR; else DATA.
//  - DATA: ready=1; byte k goes to word[8k+7:8k]; on 4th byte -> WRITE.
//  - WRITE: exactly 1 cycle, ready=0, wr_en=1, addr=word index, data=packed word.
//    Index increments; index==N -> RUN (or CHK), else DATA.
//  - Latency: wr_en asserts the cycle after the 4th byte handshake.
//    Max throughput: 4 bytes / 5 cycles.
//  - RUN: ready=0, cpu_rstn=1, done=1. i_ldr_start -> HDR.
//    cpu_rstn and done drop on the cycle the state changes; imem is then overwritten from word 0.
//  - ERR: ready=0, err=1, cpu_rstn=0. Left only via i_ldr_start (-> HDR) or i_rst.
//  - Bytes offered while ready=0 are not consumed; valid may stay high across WRITE.
//  - i_ldr_start is ignored in HDR/DATA/WRITE/CHK.
//  - i_rst mid-load: immediate return to reset state; partial imem contents left as-is.
//  - Index counter is WORD_ADDR_W+1 bits wide, so N = 2**WORD_ADDR_W completes without wrap.
// CONFIGURATION
//  RISCV_LDR_CHKSUM_EN defined:
//   - 32-bit running sum (mod 2**32) of all written words.
//   - After the last WRITE (or N=0), state CHK takes 4 more bytes, LSB first.
//   - Match -> RUN; mismatch -> ERR.
//  Not defined: no CHK state, no adder; last WRITE -> RUN directly.
// STRUCTURE
//  - Shared package/header riscv_ldr_defs.vh:
//    - State encodings LDR_IDLE/HDR/DATA/WRITE/RUN/ERR/CHK (3-bit).
//    - LDR_BYTES_PER_WORD = 4.
//  - One sub-module riscv_ldr_packer: byte counter + shift register; emits word_valid when
//    word is full; cleared by FSM. FSM, index counter and checksum stay in the top.
// TESTING
//  1. AUTO_START=1, stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00
//     -> writes addr0=0x00000013, addr1=0x00100093; then cpu_rstn=1, done=1.
//  2. N=0 (00 00 00 00) -> RUN 1 cycle after 4th byte, no wr_en pulse.
//  3. WORD_ADDR_W=4, N=17 -> err=1, cpu_rstn=0, no writes.
//     i_ldr_start -> HDR; valid N=1 load then succeeds.
//  4. valid held high continuously -> ready low in every WRITE cycle, no byte lost.
//     Gaps in valid -> same imem contents.
//  5. i_rst pulsed after 2 bytes of word 1 -> all outputs 0.
//     Fresh full stream then loads correctly from word 0.
//  6. RISCV_LDR_CHKSUM_EN, words 0x1, 0x2:
//     checksum 03 00 00 00 -> done=1; checksum 04 00 00 00 -> err=1.

Source files
------------

// File: rtl/riscv_imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: data width, bytes per word
// and the loader FSM state encoding.
package riscv_imem_loader_pkg;

   localparam int unsigned Xlen            = 32;
   localparam int unsigned LdrBytesPerWord = 4;

   typedef enum logic [2:0] {
      LdrIdle  = 3'd0,
      LdrHdr   = 3'd1,
      LdrData  = 3'd2,
      LdrWrite = 3'd3,
      LdrRun   = 3'd4,
      LdrErr   = 3'd5,
      LdrChk   = 3'd6
   } ldr_state_e;

endpackage

// File: rtl/riscv_imem_loader_packer.sv
// Packs a little-endian byte stream into 32-bit words. word/word_valid are presented
// combinationally on the handshake of the last byte so the FSM can act on that same edge.
module riscv_imem_loader_packer
   import riscv_imem_loader_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            byte_en,
   input  logic [7:0]      byte_data,
   output logic            word_valid,
   output logic [Xlen-1:0] word
);

   localparam int unsigned CntW = $clog2(LdrBytesPerWord);

   logic [CntW-1:0] cnt_q;
   logic [Xlen-1:0] shift_q;

   // New bytes enter at the top, so after four bytes the first one sits in [7:0].
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (byte_en) begin
         cnt_q   <= cnt_q + 1'b1;
         shift_q <= {byte_data, shift_q[Xlen-1:8]};
      end
   end

   assign word_valid = byte_en && (cnt_q == CntW'(LdrBytesPerWord - 1));
   assign word       = {byte_data, shift_q[Xlen-1:8]};

endmodule

// File: rtl/riscv_imem_loader.sv
// Boot loader: receives word count + words as a byte stream, writes imem, then releases
// the CPU reset. Optional trailing checksum when RISCV_LDR_CHKSUM_EN is defined.
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 12
`endif

module riscv_imem_loader
   import riscv_imem_loader_pkg::*;
#(
   parameter int unsigned WORD_ADDR_W = `IMEM_ADDR_BIT - 2,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_ldr_start,
   input  logic                   i_ldr_valid,
   input  logic [7:0]             i_ldr_data,
   output logic                   o_ldr_ready,
   output logic                   o_ldr_imem_wr_en,
   output logic [WORD_ADDR_W-1:0] o_ldr_imem_addr,
   output logic [Xlen-1:0]        o_ldr_imem_wr_data,
   output logic                   o_ldr_cpu_rstn,
   output logic                   o_ldr_done,
   output logic                   o_ldr_err
);

   localparam logic [Xlen:0] Cap = (Xlen + 1)'(1) << WORD_ADDR_W;
`ifdef RISCV_LDR_CHKSUM_EN
   localparam ldr_state_e DoneSt = LdrChk;
`else
   localparam ldr_state_e DoneSt = LdrRun;
`endif

   ldr_state_e             state_q, state_d;
   logic [WORD_ADDR_W:0]   idx_q, n_q;
   logic                   byte_en, pk_clr, pk_valid;
   logic [Xlen-1:0]        pk_word;
`ifdef RISCV_LDR_CHKSUM_EN
   logic [Xlen-1:0]        sum_q;
`endif

   assign byte_en = i_ldr_valid & o_ldr_ready;
   assign pk_clr  = (state_q == LdrIdle) || (state_q == LdrRun) || (state_q == LdrErr);

   riscv_imem_loader_packer u_packer (
      .clk        (i_clk),
      .rst        (i_rst),
      .clr        (pk_clr),
      .byte_en    (byte_en),
      .byte_data  (i_ldr_data),
      .word_valid (pk_valid),
      .word       (pk_word)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LdrIdle: if (i_ldr_start) state_d = LdrHdr;
         LdrHdr: begin
            if (pk_valid) begin
               if (pk_word == '0)              state_d = DoneSt;
               else if ({1'b0, pk_word} > Cap) state_d = LdrErr;
               else                            state_d = LdrData;
            end
         end
         LdrData:  if (pk_valid) state_d = LdrWrite;
         LdrWrite: state_d = (idx_q + 1'b1 == n_q) ? DoneSt : LdrData;
         LdrRun:   if (i_ldr_start) state_d = LdrHdr;
         LdrErr:   if (i_ldr_start) state_d = LdrHdr;
`ifdef RISCV_LDR_CHKSUM_EN
         LdrChk:   if (pk_valid) state_d = (pk_word == sum_q) ? LdrRun : LdrErr;
`endif
         default:  state_d = LdrIdle;
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q            <= AUTO_START ? LdrHdr : LdrIdle;
         idx_q              <= '0;
         n_q                <= '0;
         o_ldr_ready        <= 1'b0;
         o_ldr_imem_wr_en   <= 1'b0;
         o_ldr_imem_addr    <= '0;
         o_ldr_imem_wr_data <= '0;
         o_ldr_cpu_rstn     <= 1'b0;
         o_ldr_done         <= 1'b0;
         o_ldr_err          <= 1'b0;
`ifdef RISCV_LDR_CHKSUM_EN
         sum_q              <= '0;
`endif
      end else begin
         state_q          <= state_d;
         o_ldr_ready      <= (state_d == LdrHdr) || (state_d == LdrData) || (state_d == LdrChk);
         o_ldr_imem_wr_en <= (state_d == LdrWrite);
         o_ldr_cpu_rstn   <= (state_d == LdrRun);
         o_ldr_done       <= (state_d == LdrRun);
         o_ldr_err        <= (state_d == LdrErr);
         if (state_q == LdrHdr && pk_valid) n_q <= pk_word[WORD_ADDR_W:0];
         if (state_q == LdrHdr)        idx_q <= '0;
         else if (state_q == LdrWrite) idx_q <= idx_q + 1'b1;
         if (state_q == LdrData && pk_valid) begin
            o_ldr_imem_addr    <= idx_q[WORD_ADDR_W-1:0];
            o_ldr_imem_wr_data <= pk_word;
         end
`ifdef RISCV_LDR_CHKSUM_EN
         if (state_q == LdrHdr)                   sum_q <= '0;
         else if (state_q == LdrData && pk_valid) sum_q <= sum_q + pk_word;
`endif
      end
   end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader (WORD_ADDR_W=4, AUTO_START=1).
module tb_riscv_imem_loader;

   logic        clk = 1'b0;
   logic        i_rst, i_ldr_start, i_ldr_valid;
   logic [7:0]  i_ldr_data;
   logic        o_ldr_ready, o_ldr_imem_wr_en, o_ldr_cpu_rstn, o_ldr_done, o_ldr_err;
   logic [3:0]  o_ldr_imem_addr;
   logic [31:0] o_ldr_imem_wr_data;

   int checks = 0, failures = 0;
   int wr_cnt = 0, viol = 0;
   logic [3:0]  log_addr [0:255];
   logic [31:0] log_data [0:255];
   logic [31:0] stim [0:31];

   always #5 clk = ~clk;

   riscv_imem_loader #(.WORD_ADDR_W(4), .AUTO_START(1'b1)) dut (
      .i_clk              (clk),
      .i_rst              (i_rst),
      .i_ldr_start        (i_ldr_start),
      .i_ldr_valid        (i_ldr_valid),
      .i_ldr_data         (i_ldr_data),
      .o_ldr_ready        (o_ldr_ready),
      .o_ldr_imem_wr_en   (o_ldr_imem_wr_en),
      .o_ldr_imem_addr    (o_ldr_imem_addr),
      .o_ldr_imem_wr_data (o_ldr_imem_wr_data),
      .o_ldr_cpu_rstn     (o_ldr_cpu_rstn),
      .o_ldr_done         (o_ldr_done),
      .o_ldr_err          (o_ldr_err)
   );

   // Write logger: records every imem write and any write cycle where ready is not low.
   always @(posedge clk) begin
      #1;
      if (o_ldr_imem_wr_en === 1'b1) begin
         log_addr[wr_cnt[7:0]] = o_ldr_imem_addr;
         log_data[wr_cnt[7:0]] = o_ldr_imem_wr_data;
         if (o_ldr_ready !== 1'b0) viol++;
         wr_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit hold, input int gap);
      int t = 0;
      i_ldr_valid = 1'b1;
      i_ldr_data  = b;
      while (o_ldr_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         checks++; failures++;
         $display("FAIL handshake_timeout: ready=%b required=1", o_ldr_ready);
      end
      @(negedge clk);
      if (!hold) begin
         i_ldr_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit hold, input int gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], hold, gap);
   endtask

   task automatic pulse_start();
      i_ldr_start = 1'b1;
      @(negedge clk);
      i_ldr_start = 1'b0;
   endtask

   task automatic wait_end(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (o_ldr_done === 1'b1 || o_ldr_err === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic load(input int n, input bit hold, input int gap);
      logic [31:0] sum = '0;
      send_word(n, hold, gap);
      for (int i = 0; i < n; i++) begin
         send_word(stim[i], hold, gap);
         sum += stim[i];
      end
`ifdef RISCV_LDR_CHKSUM_EN
      send_word(sum, hold, gap);
`endif
      i_ldr_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_ldr_start = 1'b0; i_ldr_valid = 1'b0; i_ldr_data = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_ldr_ready, o_ldr_imem_wr_en, o_ldr_cpu_rstn, o_ldr_done, o_ldr_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs: rdy/we/rstn/done/err=%b required=00000",
                  {o_ldr_ready, o_ldr_imem_wr_en, o_ldr_cpu_rstn, o_ldr_done, o_ldr_err});
      end
      checks++;
      if (o_ldr_imem_addr !== 4'h0 || o_ldr_imem_wr_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_addr_data: addr=%h data=%h required 0/0",
                  o_ldr_imem_addr, o_ldr_imem_wr_data);
      end
      i_rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (o_ldr_ready !== 1'b1) begin
         failures++;
         $display("FAIL autostart_ready: ready=%b required=1", o_ldr_ready);
      end
   endtask

   task automatic test_basic();
      int base = wr_cnt;
      bit ok;
      send_word(32'd2, 1'b0, 0);
      send_word(32'h0000_0013, 1'b0, 0);
      send_word(32'h0010_0093, 1'b0, 0);
      checks++;
      if (o_ldr_imem_wr_en !== 1'b1 || o_ldr_imem_addr !== 4'd1
          || o_ldr_imem_wr_data !== 32'h0010_0093) begin
         failures++;
         $display("FAIL write_latency: we=%b addr=%h data=%h required 1/1/00100093",
                  o_ldr_imem_wr_en, o_ldr_imem_addr, o_ldr_imem_wr_data);
      end
`ifdef RISCV_LDR_CHKSUM_EN
      send_word(32'h0010_00A6, 1'b0, 0);
`endif
      wait_end(ok);
      checks++;
      if (!ok || o_ldr_done !== 1'b1 || o_ldr_cpu_rstn !== 1'b1 || o_ldr_err !== 1'b0) begin
         failures++;
         $display("FAIL basic_run: done=%b rstn=%b err=%b required 1/1/0",
                  o_ldr_done, o_ldr_cpu_rstn, o_ldr_err);
      end
      checks++;
      if (wr_cnt - base !== 2 || log_addr[base[7:0]] !== 4'd0
          || log_data[base[7:0]] !== 32'h13 || log_addr[8'(base + 1)] !== 4'd1
          || log_data[8'(base + 1)] !== 32'h0010_0093) begin
         failures++;
         $display("FAIL basic_writes: n=%0d w0=%h@%h w1=%h@%h required 2 13@0 00100093@1",
                  wr_cnt - base, log_data[base[7:0]], log_addr[base[7:0]],
                  log_data[8'(base + 1)], log_addr[8'(base + 1)]);
      end
   endtask

   task automatic test_zero_words();
      int base;
      pulse_start();
      checks++;
      if (o_ldr_cpu_rstn !== 1'b0 || o_ldr_done !== 1'b0) begin
         failures++;
         $display("FAIL restart_drop: rstn=%b done=%b required 0/0", o_ldr_cpu_rstn, o_ldr_done);
      end
      base = wr_cnt;
      send_word(32'd0, 1'b0, 0);
`ifdef RISCV_LDR_CHKSUM_EN
      send_word(32'd0, 1'b0, 0);
`endif
      checks++;
      if (o_ldr_done !== 1'b1 || o_ldr_cpu_rstn !== 1'b1) begin
         failures++;
         $display("FAIL zero_latency: done=%b rstn=%b required 1/1", o_ldr_done, o_ldr_cpu_rstn);
      end
      checks++;
      if (wr_cnt !== base) begin
         failures++;
         $display("FAIL zero_no_write: writes=%0d required=0", wr_cnt - base);
      end
   endtask

   task automatic test_overflow();
      int base = wr_cnt;
      bit ok;
      pulse_start();
      send_word(32'd17, 1'b0, 0);
      checks++;
      if (o_ldr_err !== 1'b1 || o_ldr_cpu_rstn !== 1'b0 || o_ldr_done !== 1'b0
          || o_ldr_ready !== 1'b0) begin
         failures++;
         $display("FAIL overflow_err: err=%b rstn=%b done=%b rdy=%b required 1/0/0/0",
                  o_ldr_err, o_ldr_cpu_rstn, o_ldr_done, o_ldr_ready);
      end
      checks++;
      if (wr_cnt !== base) begin
         failures++;
         $display("FAIL overflow_no_write: writes=%0d required=0", wr_cnt - base);
      end
      pulse_start();
      checks++;
      if (o_ldr_err !== 1'b0 || o_ldr_ready !== 1'b1) begin
         failures++;
         $display("FAIL err_restart: err=%b rdy=%b required 0/1", o_ldr_err, o_ldr_ready);
      end
      // A start pulse mid-header must be ignored.
      send_byte(8'h01, 1'b0, 0);
      pulse_start();
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h00, 1'b0, 0);
      send_byte(8'h00, 1'b0, 0);
      send_word(32'hDEAD_BEEF, 1'b0, 0);
`ifdef RISCV_LDR_CHKSUM_EN
      send_word(32'hDEAD_BEEF, 1'b0, 0);
`endif
      wait_end(ok);
      checks++;
      if (!ok || o_ldr_done !== 1'b1 || wr_cnt - base !== 1 || log_addr[base[7:0]] !== 4'd0
          || log_data[base[7:0]] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL recover_load: done=%b n=%0d w0=%h@%h required 1 1 deadbeef@0",
                  o_ldr_done, wr_cnt - base, log_data[base[7:0]], log_addr[base[7:0]]);
      end
   endtask

   task automatic test_full_capacity();
      int base, bad = 0;
      bit ok;
      for (int i = 0; i < 16; i++) stim[i] = 32'hA500_0000 | i;
      pulse_start();
      base = wr_cnt;
      load(16, 1'b0, 0);
      wait_end(ok);
      checks++;
      if (!ok || o_ldr_done !== 1'b1 || o_ldr_err !== 1'b0 || wr_cnt - base !== 16) begin
         failures++;
         $display("FAIL full_done: done=%b err=%b n=%0d required 1/0/16",
                  o_ldr_done, o_ldr_err, wr_cnt - base);
      end
      for (int i = 0; i < 16; i++)
         if (log_addr[8'(base + i)] !== 4'(i) || log_data[8'(base + i)] !== (32'hA500_0000 | i))
            bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL full_contents: bad_words=%0d required=0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int base, bad;
      bit ok;
      stim[0] = 32'h1122_3344; stim[1] = 32'h5566_7788; stim[2] = 32'h99AA_BBCC;
      for (int pass = 0; pass < 2; pass++) begin
         pulse_start();
         base = wr_cnt;
         bad  = 0;
         if (pass == 0) load(3, 1'b1, 0);
         else           load(3, 1'b0, 2);
         wait_end(ok);
         for (int i = 0; i < 3; i++)
            if (log_addr[8'(base + i)] !== 4'(i) || log_data[8'(base + i)] !== stim[i]) bad++;
         checks++;
         if (!ok || o_ldr_done !== 1'b1 || wr_cnt - base !== 3 || bad != 0) begin
            failures++;
            $display("FAIL b2b_pass%0d: done=%b n=%0d bad=%0d required 1/3/0",
                     pass, o_ldr_done, wr_cnt - base, bad);
         end
      end
      checks++;
      if (viol !== 0) begin
         failures++;
         $display("FAIL ready_in_write: cycles=%0d required=0", viol);
      end
   endtask

   task automatic test_reset_mid_load();
      int base, bad = 0;
      bit ok;
      pulse_start();
      send_word(32'd2, 1'b0, 0);
      send_word(32'hCAFE_F00D, 1'b0, 0);
      send_byte(8'h11, 1'b0, 0);
      send_byte(8'h22, 1'b0, 0);
      i_rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({o_ldr_ready, o_ldr_imem_wr_en, o_ldr_cpu_rstn, o_ldr_done, o_ldr_err} !== 5'b0) begin
         failures++;
         $display("FAIL midload_reset: rdy/we/rstn/done/err=%b required=00000",
                  {o_ldr_ready, o_ldr_imem_wr_en, o_ldr_cpu_rstn, o_ldr_done, o_ldr_err});
      end
      i_rst = 1'b0;
      stim[0] = 32'h0BAD_F00D; stim[1] = 32'h1234_5678;
      base = wr_cnt;
      load(2, 1'b0, 0);
      wait_end(ok);
      for (int i = 0; i < 2; i++)
         if (log_addr[8'(base + i)] !== 4'(i) || log_data[8'(base + i)] !== stim[i]) bad++;
      checks++;
      if (!ok || o_ldr_done !== 1'b1 || wr_cnt - base !== 2 || bad != 0) begin
         failures++;
         $display("FAIL reload_after_reset: done=%b n=%0d bad=%0d required 1/2/0",
                  o_ldr_done, wr_cnt - base, bad);
      end
   endtask

`ifdef RISCV_LDR_CHKSUM_EN
   task automatic test_checksum();
      bit ok;
      for (int pass = 0; pass < 2; pass++) begin
         pulse_start();
         send_word(32'd2, 1'b0, 0);
         send_word(32'd1, 1'b0, 0);
         send_word(32'd2, 1'b0, 0);
         send_word((pass == 0) ? 32'd3 : 32'd4, 1'b0, 0);
         wait_end(ok);
         checks++;
         if (!ok || o_ldr_done !== (pass == 0) || o_ldr_err !== (pass != 0)) begin
            failures++;
            $display("FAIL checksum_pass%0d: done=%b err=%b required %b/%b",
                     pass, o_ldr_done, o_ldr_err, pass == 0, pass != 0);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero_words();
      test_overflow();
      test_full_capacity();
      test_back_to_back();
      test_reset_mid_load();
`ifdef RISCV_LDR_CHKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
